sw_debounce_sync: RTL

- Conditions the raw board slide switches before they reach the SoC's buttons PIO export.
- Per bit: 2-FF synchronizer, debounce counter, registered stable level, single-cycle rise/fall pulses, sticky edge-capture bits with per-bit clear.
- Presents a packed 32-bit word that drives the buttons export directly: stable level in [7:0], edge-capture in [15:8], zeros above.

---
 rtl/soc_io_pkg.sv | 11 +
 rtl/debounce_bit.sv | 53 +++++
 rtl/sw_debounce_sync.sv | 56 +++++
 3 files changed

// File: rtl/soc_io_pkg.sv
// Shared constants for the SoC switch/button I/O path: widths, export packing
// offsets and the default debounce interval.
package soc_io_pkg;

  localparam int SW_WIDTH            = 8;
  localparam int EXPORT_W            = 32;
  localparam int STABLE_LSB          = 0;
  localparam int EDGE_LSB            = 8;
  localparam int DEBOUNCE_10MS_50MHZ = 500000;

endpackage : soc_io_pkg

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchronizer, consecutive-mismatch counter, registered
// stable level and single-cycle rise/fall pulses.
module debounce_bit
  import soc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // High on the edge where a new level is taken; the pulses follow one cycle later.
  assign accept = (s2 != stable) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= s2;
        cnt    <= '0;
        rise   <= s2;
        fall   <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : debounce_bit

// File: rtl/sw_debounce_sync.sv
// Debounced slide-switch bank: per-bit conditioning, sticky edge capture with
// per-bit clear, and the packed word feeding the buttons PIO export.
module sw_debounce_sync
  import soc_io_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    sw_raw,
  input  logic [WIDTH-1:0]    edge_clr,
  output logic [WIDTH-1:0]    sw_stable,
  output logic [WIDTH-1:0]    sw_rise,
  output logic [WIDTH-1:0]    sw_fall,
  output logic                any_change,
  output logic [WIDTH-1:0]    edge_cap,
  output logic [EXPORT_W-1:0] export_word
);

  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i]),
      .accept (accept[i])
    );
  end

  // any_change is registered from the same condition as the pulses so it lines up with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change <= 1'b0;
      edge_cap   <= '0;
    end else begin
      any_change <= |accept;
      edge_cap   <= (sw_rise | sw_fall) | (edge_cap & ~edge_clr);
    end
  end

  always_comb begin
    export_word = '0;
    export_word[STABLE_LSB +: WIDTH] = sw_stable;
    export_word[EDGE_LSB   +: WIDTH] = edge_cap;
  end

endmodule : sw_debounce_sync
